// File: rtl/coder_capture_ctrl.sv
// Capture sequencer: arms on command, triggers on a programmable sample class code and packs
// 16 codes per 32-bit word onto a valid/ready stream. Optional trigger holdoff: CODER_HOLDOFF_EN.

module coder_vector #(
    parameter int unsigned     size   = 16,
    parameter logic [size-1:0] data_a = 16'habad,
    parameter logic [size-1:0] data_b = 16'hface
) (
    input  logic [size-1:0] data,
    output logic [1:0]      code
);
    always_comb begin
        if (data == '0)          code = 2'b00;
        else if (data == data_a) code = 2'b01;
        else if (data == data_b) code = 2'b10;
        else                     code = 2'b11;
    end
endmodule

module coder_capture_ctrl #(
    parameter int unsigned     size   = 16,
    parameter logic [size-1:0] data_a = 16'habad,
    parameter logic [size-1:0] data_b = 16'hface,
    parameter int unsigned     len_w  = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic [1:0]       trig_code,
    input  logic [len_w-1:0] capture_len,
    input  logic             sample_stb,
    input  logic [size-1:0]  data,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       trig_q, trig_d;
    logic [len_w-1:0] len_q, len_d;
    logic [len_w-1:0] word_cnt_q, word_cnt_d, word_cnt_inc;
    logic [3:0]       slot_q, slot_d;
    logic [29:0]      pack_q, pack_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic [1:0]       code;
    logic             trig_hit;
    logic             arm_ok;

    coder_vector #(.size(size), .data_a(data_a), .data_b(data_b)) u_coder (
        .data (data),
        .code (code)
    );

    assign arm_ok       = arm && (state_q == ST_IDLE || state_q == ST_DONE);
    assign word_cnt_inc = word_cnt_q + len_w'(1);

`ifdef CODER_HOLDOFF_EN
    // Trigger only on the 4th consecutive matching strobe.
    logic [1:0] run_q, run_d;

    assign trig_hit = sample_stb && (code == trig_q) && (run_q == 2'd3);

    always_comb begin
        run_d = run_q;
        if (abort || arm_ok) begin
            run_d = 2'd0;
        end else if (state_q == ST_ARMED && sample_stb) begin
            if (code != trig_q || run_q == 2'd3) run_d = 2'd0;
            else                                  run_d = run_q + 2'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) run_q <= 2'd0;
        else            run_q <= run_d;
    end
`else
    assign trig_hit = sample_stb && (code == trig_q);
`endif

    always_comb begin
        state_d     = state_q;
        trig_d      = trig_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        slot_d      = slot_q;
        pack_d      = pack_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            slot_d      = 4'd0;
            word_cnt_d  = '0;
            overflow_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        trig_d     = trig_code;
                        len_d      = capture_len;
                        slot_d     = 4'd0;
                        word_cnt_d = '0;
                        pack_d     = '0;
                        overflow_d = 1'b0;
                        state_d    = (capture_len == '0) ? ST_DONE : ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        pack_d[1:0] = code;
                        slot_d      = 4'd1;
                        state_d     = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_stb) begin
                        slot_d = slot_q + 4'd1;
                        if (slot_q != 4'd15) begin
                            pack_d[{slot_q, 1'b0} +: 2] = code;
                        end else begin
                            // Slot 15 goes straight into the outgoing word.
                            if (!out_valid_q || out_ready) begin
                                out_data_d  = {code, pack_q};
                                out_valid_d = 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                            word_cnt_d = word_cnt_inc;
                            if (word_cnt_inc == len_q) state_d = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            trig_q      <= 2'd0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            slot_q      <= 4'd0;
            pack_q      <= '0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trig_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            slot_q      <= slot_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign state     = state_q;
    assign busy      = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE) && !out_valid_q;
endmodule

// File: tb/tb_coder_capture_ctrl.sv
// Bench for coder_capture_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model. Honours CODER_HOLDOFF_EN for the trigger rule.

module tb_coder_capture_ctrl;
`ifdef CODER_HOLDOFF_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 1;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        arm = 1'b0, abort = 1'b0, sample_stb = 1'b0, out_ready = 1'b0;
    logic [1:0]  trig_code = 2'd0;
    logic [7:0]  capture_len = 8'd0;
    logic [15:0] data = 16'd0;
    logic [31:0] out_data;
    logic        out_valid, busy, done, overflow;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    int          m_st, m_len, m_words, m_run;
    logic [1:0]  m_trig;
    logic [1:0]  m_q[$];
    logic        m_vld, m_ovf;
    logic [31:0] m_data;

    always #5 sys_clk = ~sys_clk;

    coder_capture_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .arm         (arm),
        .abort       (abort),
        .trig_code   (trig_code),
        .capture_len (capture_len),
        .sample_stb  (sample_stb),
        .data        (data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .state       (state)
    );

    function automatic logic [1:0] cls(input logic [15:0] d);
        if (d == 16'h0000) return 2'b00;
        if (d == 16'habad) return 2'b01;
        if (d == 16'hface) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [15:0] data_for(input logic [1:0] c);
        case (c)
            2'b00:   return 16'h0000;
            2'b01:   return 16'habad;
            2'b10:   return 16'hface;
            default: return 16'h0001 + 16'($urandom % 256);
        endcase
    endfunction

    function automatic logic [15:0] rnd_data();
        return data_for(2'($urandom % 4));
    endfunction

    task automatic cyc(input logic a, input logic ab, input logic s, input logic [15:0] d, input logic r);
        arm = a; abort = ab; sample_stb = s; data = d; out_ready = r;
        @(posedge sys_clk); #1;
        arm = 1'b0; abort = 1'b0; sample_stb = 1'b0;
    endtask

    task automatic do_trigger(input logic [15:0] d);
        for (int i = 0; i < HOLD; i++) cyc(1'b0, 1'b0, 1'b1, d, out_ready);
    endtask

    task automatic model_step(input logic a, input logic ab, input logic s, input logic [15:0] d,
                              input logic r, input logic [1:0] tc, input logic [7:0] cl);
        logic [1:0]  c;
        logic        old_v;
        logic [31:0] w;
        c = cls(d);
        old_v = m_vld;
        if (m_vld && r) m_vld = 1'b0;
        if (ab) begin
            m_st = 0; m_vld = 1'b0; m_q.delete(); m_words = 0; m_ovf = 1'b0; m_run = 0;
        end else if ((m_st == 0 || m_st == 3) && a) begin
            m_trig = tc; m_len = int'(cl); m_q.delete(); m_words = 0; m_ovf = 1'b0; m_run = 0;
            m_st = (cl == 8'd0) ? 3 : 1;
        end else if (m_st == 1 && s) begin
            if (c == m_trig) begin
                m_run++;
                if (m_run == HOLD) begin m_run = 0; m_q.push_back(c); m_st = 2; end
            end else begin
                m_run = 0;
            end
        end else if (m_st == 2 && s) begin
            m_q.push_back(c);
            if (m_q.size() == 16) begin
                w = 32'd0;
                foreach (m_q[k]) w = w | (32'(m_q[k]) << (2 * k));
                m_q.delete();
                if (!old_v || r) begin m_data = w; m_vld = 1'b1; end
                else m_ovf = 1'b1;
                m_words++;
                if (m_words == m_len) m_st = 3;
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b exp 00", state); end
        n_cmp++; if ({out_valid, busy, done, overflow} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_flags: got v/b/d/o=%b exp 0000", {out_valid, busy, done, overflow}); end
        n_cmp++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", out_data); end
    endtask

    task automatic test_basic();
        trig_code = 2'b01; capture_len = 8'd1;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        n_cmp++; if ({state, busy} !== 3'b011) begin n_fail++; $display("FAIL basic_armed: got st/busy=%b exp 011", {state, busy}); end
        do_trigger(16'habad);
        n_cmp++; if (state !== 2'b10) begin n_fail++; $display("FAIL basic_trig: got %b exp 10", state); end
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        n_cmp++; if (out_data !== 32'h00000001 || out_valid !== 1'b1) begin n_fail++;
            $display("FAIL basic_word: got %h v=%b exp 00000001 v=1", out_data, out_valid); end
        n_cmp++; if ({state, done} !== 3'b110) begin n_fail++; $display("FAIL basic_pending: got st/done=%b exp 110", {state, done}); end
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        n_cmp++; if ({state, done, out_valid, busy} !== 5'b11100) begin n_fail++;
            $display("FAIL basic_done: got st/done/v/busy=%b exp 11100", {state, done, out_valid, busy}); end
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_overflow();
        trig_code = 2'b10; capture_len = 8'd2;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        do_trigger(16'hface);
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 16'hface, 1'b0);
            if (i == 15) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'haaaaaaaa || overflow !== 1'b0) begin n_fail++;
                    $display("FAIL ovf_first: got %h v=%b o=%b exp aaaaaaaa v=1 o=0", out_data, out_valid, overflow); end
            end
        end
        n_cmp++; if (out_data !== 32'haaaaaaaa || out_valid !== 1'b1) begin n_fail++;
            $display("FAIL ovf_held: got %h v=%b exp aaaaaaaa v=1", out_data, out_valid); end
        n_cmp++; if ({state, overflow, done} !== 4'b1110) begin n_fail++;
            $display("FAIL ovf_flags: got st/o/done=%b exp 1110", {state, overflow, done}); end
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        n_cmp++; if ({done, out_valid, overflow} !== 3'b101) begin n_fail++;
            $display("FAIL ovf_done: got done/v/o=%b exp 101", {done, out_valid, overflow}); end
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  codes[$];
        logic [15:0] d;
        logic [31:0] w;
        trig_code = 2'b00; capture_len = 8'd4;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        do_trigger(16'h0000);
        codes.push_back(2'b00);
        for (int n = 1; n < 64; n++) begin
            d = rnd_data();
            codes.push_back(cls(d));
            cyc(1'b0, 1'b0, 1'b1, d, 1'b1);
            n_cmp++; if (out_valid !== ((n % 16) == 15)) begin n_fail++;
                $display("FAIL b2b_valid n=%0d: got %b exp %b", n, out_valid, (n % 16) == 15); end
            if ((n % 16) == 15) begin
                w = 32'd0;
                for (int k = 0; k < 16; k++) w = w | (32'(codes[k]) << (2 * k));
                codes.delete();
                n_cmp++; if (out_data !== w) begin n_fail++; $display("FAIL b2b_word n=%0d: got %h exp %h", n, out_data, w); end
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        n_cmp++; if ({state, done, overflow} !== 4'b1110) begin n_fail++;
            $display("FAIL b2b_end: got st/done/o=%b exp 1110", {state, done, overflow}); end
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_abort();
        trig_code = 2'b11; capture_len = 8'd1;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        do_trigger(16'h1234);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, rnd_data(), 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
        n_cmp++; if ({state, out_valid, busy, done} !== 5'b00000) begin n_fail++;
            $display("FAIL abort_idle: got st/v/busy/done=%b exp 00000", {state, out_valid, busy, done}); end
        trig_code = 2'b01;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        do_trigger(16'habad);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1, 16'hface, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'haaaaaaa9) begin n_fail++;
            $display("FAIL abort_rearm: got %h v=%b exp aaaaaaa9 v=1", out_data, out_valid); end
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_len_zero();
        trig_code = 2'b01; capture_len = 8'd0;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        n_cmp++; if ({state, done, out_valid, busy} !== 5'b11100) begin n_fail++;
            $display("FAIL len0: got st/done/v/busy=%b exp 11100", {state, done, out_valid, busy}); end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 16'habad, 1'b0);
        n_cmp++; if ({state, out_valid} !== 3'b110) begin n_fail++;
            $display("FAIL len0_ignore: got st/v=%b exp 110", {state, out_valid}); end
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_trigger_rule();
        logic [15:0] seq[7];
        trig_code = 2'b01; capture_len = 8'd1;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
`ifdef CODER_HOLDOFF_EN
        seq = '{16'habad, 16'habad, 16'h0000, 16'habad, 16'habad, 16'habad, 16'habad};
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 1'b1, seq[i], 1'b0);
            n_cmp++; if (state !== ((i == 6) ? 2'b10 : 2'b01)) begin n_fail++;
                $display("FAIL holdoff_step%0d: got %b exp %b", i, state, (i == 6) ? 2'b10 : 2'b01); end
        end
`else
        seq = '{16'h0000, 16'hface, 16'h4321, 16'habad, 16'h0, 16'h0, 16'h0};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, seq[i], 1'b0);
            n_cmp++; if (state !== ((i == 3) ? 2'b10 : 2'b01)) begin n_fail++;
                $display("FAIL trig_step%0d: got %b exp %b", i, state, (i == 3) ? 2'b10 : 2'b01); end
        end
`endif
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00000001) begin n_fail++;
            $display("FAIL trig_word: got %h v=%b exp 00000001 v=1", out_data, out_valid); end
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        trig_code = 2'b10; capture_len = 8'd2;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        do_trigger(16'hface);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, 16'hface, 1'b0);
        #2 sys_rst_n = 1'b0;
        #1;
        n_cmp++; if ({state, out_valid, busy, done, overflow} !== 6'd0 || out_data !== 32'd0) begin n_fail++;
            $display("FAIL reset_mid: got st/v/b/d/o=%b data=%h exp all 0", {state, out_valid, busy, done, overflow}, out_data); end
        #2 sys_rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic        a, ab, s, r;
        logic [15:0] d;
        logic [37:0] got, exp;
        for (int run = 0; run < 5; run++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
            model_step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 2'b0, 8'd0);
            for (int t = 0; t < 400; t++) begin
                a  = ($urandom % 16) == 0;
                ab = ($urandom % 200) == 0;
                s  = ($urandom % 4) != 0;
                r  = ($urandom % 2) == 1;
                d  = (($urandom % 2) == 1) ? data_for(m_trig) : rnd_data();
                trig_code   = 2'($urandom % 4);
                capture_len = 8'($urandom % 4);
                cyc(a, ab, s, d, r);
                model_step(a, ab, s, d, r, trig_code, capture_len);
                exp = {2'(m_st), m_vld, m_ovf, (m_st == 3) && !m_vld, (m_st == 1) || (m_st == 2),
                       m_vld ? m_data : 32'h0};
                got = {state, out_valid, overflow, done, busy, out_valid ? out_data : 32'h0};
                n_cmp++; if (got !== exp) begin n_fail++;
                    $display("FAIL random r%0d t%0d: got %h exp %h", run, t, got, exp); end
            end
        end
    endtask

    initial begin
        m_st = 0; m_len = 0; m_words = 0; m_run = 0; m_trig = 2'b0;
        m_vld = 1'b0; m_ovf = 1'b0; m_data = 32'h0;
        repeat (2) @(posedge sys_clk);
        #1;
        test_reset();
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_len_zero();
        test_trigger_rule();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/coder_capture_ctrl.md
# coder_capture_ctrl

Sequencing controller for the sampling path's word classifier. It arms on command and waits for a programmable 2-bit class code (zero / pattern A / pattern B / other) on strobed samples. From the trigger onward it packs 16 consecutive codes per 32-bit word and delivers the words over a valid/ready stream, up to a programmed word count. It sits between the sampled bus and the monitor's readout FIFO, and instantiates `coder_vector` internally for classification.

## Interface
- `size`, 16, sample width; passed to `coder_vector`.
- `data_a`, 16'habad, pattern classified as code 01.
- `data_b`, 16'hface, pattern classified as code 10.
- `len_w`, 8, width of capture-length and word counters.
- Clock and reset: one clock, `sys_clk`; asynchronous, active-low reset, `sys_rst_n`.
- `sys_clk`  in  1  system clock, all logic rising-edge.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `arm`  in  1  single-cycle start request.
- `abort`  in  1  single-cycle cancel; returns to IDLE.
- `trig_code`  in  2  class code that triggers capture; latched on arm.
- `capture_len`  in  len_w  number of 32-bit words to deliver; latched on arm.
- `sample_stb`  in  1  `data` is a valid sample this cycle.
- `data`  in  size  sampled word.
- `out_data`  out  32  packed codes; slot k occupies bits [2k+1:2k], slot 0 is the oldest.
- `out_valid`  out  1  `out_data` holds an undelivered word.
- `out_ready`  in  1  consumer accepts the word when high together with `out_valid`.
- `busy`  out  1  state is ARMED or CAPTURE.
- `done`  out  1  state is DONE and no word is pending.
- `overflow`  out  1  sticky; at least one word was dropped.
- `state`  out  2  IDLE=00, ARMED=01, CAPTURE=10, DONE=11.

## Operation
- The code is combinational from `data` (00 zero, 01 data_a, 10 data_b, 11 other). It is used only in cycles where `sample_stb`=1.
- **IDLE**
  - On `arm`: latch `trig_code` and `capture_len`; clear the slot counter, word counter, pack register, `overflow` and `done`.
  - Then go to ARMED, or directly to DONE if `capture_len`=0.
- **ARMED**
  - On `sample_stb` with code==`trig_code`: go to CAPTURE.
  - The triggering sample is stored as slot 0.
- **CAPTURE**
  - Each `sample_stb` writes its code into the current slot and increments the slot counter, which is 4 bits and wraps 15→0.
  - On slot 15, the word is complete.
    - If `out_valid`=0, or `out_valid`&`out_ready` in the same cycle, load `out_data` and set `out_valid`.
    - Otherwise drop the word and set `overflow`.
    - In both cases the word counter increments.
  - When the word counter reaches `capture_len`, go to DONE.
- **DONE**
  - `arm` re-arms exactly as from IDLE. If a word is still pending, it stays valid and is not cleared.
- `arm` in ARMED or CAPTURE is ignored.
- `abort` in any state:
  - goes to IDLE and clears `out_valid`, the slot counter and the word counter;
  - clears `overflow` and `done`;
  - takes priority over a simultaneous `arm` or `sample_stb`.
- `sample_stb` in IDLE or DONE is ignored.
- `out_valid` falls on the edge where `out_valid`&`out_ready`=1, unless a new word loads on that same edge, in which case it stays 1.

## Timing
- Reset values: `state`=00, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, `overflow`=0; all counters 0.
- Trigger: `state` reads 10 the cycle after the triggering strobe.
- Word latency: `out_valid`=1 and the new `out_data` are visible the cycle after the 16th strobed sample of the word.
- `out_data` is stable while `out_valid`&!`out_ready`.
- `done` asserts the cycle after the final word completes if that word was dropped or accepted immediately. Otherwise it asserts the cycle after the final handshake.
- Consecutive strobes on every cycle are supported: sustained throughput is one word per 16 cycles with no stall.
- Reset mid-capture: all outputs return to reset values immediately (asynchronous); a partial word is discarded.

## Configuration
- `CODER_HOLDOFF_EN` defined:
  - ARMED requires 4 consecutive strobed samples with code==`trig_code`; a non-matching strobed sample resets the run count to 0.
  - Only the 4th matching sample is stored as slot 0; earlier matches are not captured.
  - The run count is cleared on `arm` and `abort`.
- `CODER_HOLDOFF_EN` undefined: a single matching sample triggers. No run counter is present.

## Test plan
- Reset, then `arm` with `trig_code`=01, `capture_len`=1 → ARMED. Strobe 16'habad, then 15×16'h0000 → `out_data`=32'h00000001, `out_valid`=1 one cycle later; handshake → `done`=1, `state`=11.
- `capture_len`=2, `out_ready`=0 throughout, 32 strobes of 16'hface after trigger code 10 → first word 32'hAAAAAAAA held, second dropped, `overflow`=1, state DONE, `done`=0 until handshake.
- Strobes every cycle, `out_ready`=1, `capture_len`=4 → 4 words at 16-cycle spacing, `overflow`=0.
- `abort` asserted together with the 10th capture strobe → `state`=00, `out_valid`=0, `busy`=0; a later `arm` starts from slot 0.
- `capture_len`=0 → `state` goes 00→11 in one cycle, `done`=1, no output word.
- With `CODER_HOLDOFF_EN`: pattern match, match, mismatch, then 4 matches → trigger on the 7th strobe, slot 0 = its code.
